alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 105 ++++++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit RV32I-style ALU with registered result and branch flags.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   en          in   1   capture enable; outputs update only when high
//   A           in  32   operand A (rs1 or PC)
//   B           in  32   operand B (rs2 or immediate)
//   aluControl  in   4   operation select (see alu_op_t)
//   aluResult   out 32   registered result
//   zero        out  1   registered: captured aluResult == 0
//   beq/bne/blt/bge/bltu/bgeu  out 1 each  registered branch-compare flags
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  aluControl,
    output logic [31:0] aluResult,
    output logic        zero,
    output logic        beq,
    output logic        bne,
    output logic        blt,
    output logic        bge,
    output logic        bltu,
    output logic        bgeu
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLT   = 4'h5,
        OP_SLTU  = 4'h6,
        OP_LUI   = 4'h7,
        OP_AUIPC = 4'h8,
        OP_PASSB = 4'h9,
        OP_SLL   = 4'hA,
        OP_SRA   = 4'hB,
        OP_SRL   = 4'hC
    } alu_op_t;

    alu_op_t     op;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [31:0] result_next;

    assign op    = alu_op_t'(aluControl);
    assign shamt = B[4:0];
    assign eq    = (A == B);
    assign lt_s  = ($signed(A) < $signed(B));
    assign lt_u  = (A < B);

    always_comb begin
        result_next = '0;
        case (op)
            OP_ADD:   result_next = A + B;
            OP_SUB:   result_next = A - B;
            OP_AND:   result_next = A & B;
            OP_OR:    result_next = A | B;
            OP_XOR:   result_next = A ^ B;
            OP_SLT:   result_next = {31'd0, lt_s};
            OP_SLTU:  result_next = {31'd0, lt_u};
            OP_LUI:   result_next = B;
            OP_AUIPC: result_next = A + B;
            OP_PASSB: result_next = B;
            OP_SLL:   result_next = A << shamt;
            OP_SRA:   result_next = $signed(A) >>> shamt;
            OP_SRL:   result_next = A >> shamt;
            // 0xD-0xF are reserved and yield a defined zero
            default:  result_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluResult <= '0;
            zero      <= 1'b0;
            beq       <= 1'b0;
            bne       <= 1'b0;
            blt       <= 1'b0;
            bge       <= 1'b0;
            bltu      <= 1'b0;
            bgeu      <= 1'b0;
        end else if (en) begin
            aluResult <= result_next;
            // zero reflects the value being captured, not the held one
            zero      <= (result_next == '0);
            beq       <= eq;
            bne       <= !eq;
            blt       <= lt_s;
            bge       <= !lt_s;
            bltu      <= lt_u;
            bgeu      <= !lt_u;
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Expected results are queued when a
// vector is driven and popped/compared one edge later when the DUT captures.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  aluControl;
    logic [31:0] aluResult;
    logic        zero;
    logic        beq, bne, blt, bge, bltu, bgeu;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        z;
        logic [5:0]  fl;
    } exp_t;

    exp_t sb[$];

    int unsigned n_vec;
    int unsigned n_mis;

    logic [31:0] last_res;
    logic        last_z;
    logic [5:0]  last_fl;

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .A          (A),
        .B          (B),
        .aluControl (aluControl),
        .aluResult  (aluResult),
        .zero       (zero),
        .beq        (beq),
        .bne        (bne),
        .blt        (blt),
        .bge        (bge),
        .bltu       (bltu),
        .bgeu       (bgeu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Flag order: {beq, bne, blt, bge, bltu, bgeu}
    function automatic logic [5:0] model_flags(input logic [31:0] a, input logic [31:0] b);
        logic e, ls, lu;
        e  = (a == b);
        lu = (a < b);
        // signed less-than via sign bits: differing signs -> A negative wins
        ls = (a[31] != b[31]) ? a[31] : lu;
        return {e, !e, ls, !ls, lu, !lu};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {beq, bne, blt, bge, bltu, bgeu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [31:0] r, input logic z,
                               input logic [5:0] f);
        chk({tag, ".res"},   aluResult,          r);
        chk({tag, ".zero"},  {31'd0, zero},      {31'd0, z});
        chk({tag, ".flags"}, {26'd0, dut_flags()}, {26'd0, f});
    endtask

    // Drive one vector at the falling edge, queue its expectation, compare
    // after the capturing rising edge.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctl, input logic [31:0] res);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        aluControl = ctl;
        en = 1'b1;
        e.tag = tag;
        e.res = res;
        e.z   = (res == 32'd0);
        e.fl  = model_flags(a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_mis++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_outputs(e.tag, e.res, e.z, e.fl);
            last_res = e.res;
            last_z   = e.z;
            last_fl  = e.fl;
        end
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        rst_n = 1'b0;
        en = 1'b1;
        A = 32'h1234_5678;
        B = 32'h0000_0001;
        aluControl = 4'h0;

        // Reset held across edges with en=1: everything stays zero
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", 32'd0, 1'b0, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Operand pair A=4, B=-5 across every opcode
        step("add",   32'd4, 32'hFFFF_FFFB, 4'h0, 32'hFFFF_FFFF);
        step("sub",   32'd4, 32'hFFFF_FFFB, 4'h1, 32'd9);
        step("and",   32'd4, 32'hFFFF_FFFB, 4'h2, 32'd0);
        step("or",    32'd4, 32'hFFFF_FFFB, 4'h3, 32'hFFFF_FFFF);
        step("xor",   32'd4, 32'hFFFF_FFFB, 4'h4, 32'hFFFF_FFFF);
        step("slt",   32'd4, 32'hFFFF_FFFB, 4'h5, 32'd0);
        step("sltu",  32'd4, 32'hFFFF_FFFB, 4'h6, 32'd1);
        step("lui",   32'd4, 32'hFFFF_FFFB, 4'h7, 32'hFFFF_FFFB);
        step("auipc", 32'd4, 32'hFFFF_FFFB, 4'h8, 32'hFFFF_FFFF);
        step("passb", 32'd4, 32'hFFFF_FFFB, 4'h9, 32'hFFFF_FFFB);
        step("sll",   32'd4, 32'hFFFF_FFFB, 4'hA, 32'h2000_0000);
        step("sra",   32'd4, 32'hFFFF_FFFB, 4'hB, 32'd0);
        step("srl",   32'd4, 32'hFFFF_FFFB, 4'hC, 32'd0);

        // Shift sign handling and upper-B-bits ignored
        step("sra_neg",  32'h8000_0000, 32'd1, 4'hB, 32'hC000_0000);
        step("srl_neg",  32'h8000_0000, 32'd1, 4'hC, 32'h4000_0000);
        step("sll_hib",  32'd1, 32'hFFFF_FFE1, 4'hA, 32'd2);
        step("sra_31",   32'h8000_0000, 32'h0000_003F, 4'hB, 32'hFFFF_FFFF);

        // Wrap-around and signed/unsigned compare corners
        step("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'h0, 32'd0);
        step("sub_wrap", 32'd0, 32'd1, 4'h1, 32'hFFFF_FFFF);
        step("slt_neg",  32'hFFFF_FFFF, 32'd1, 4'h5, 32'd1);
        step("sltu_neg", 32'hFFFF_FFFF, 32'd1, 4'h6, 32'd0);
        step("eq_7",     32'd7, 32'd7, 4'h3, 32'd7);
        chk("eq_7.flags_const", {26'd0, dut_flags()}, {26'd0, 6'b100101});

        // Latency: new inputs with en=1 must not appear before the edge
        step("lat_pre",  32'd10, 32'd3, 4'h0, 32'd13);
        @(negedge clk);
        A = 32'd10;
        B = 32'd3;
        aluControl = 4'h1;
        en = 1'b1;
        #1;
        chk_outputs("lat_before_edge", last_res, last_z, last_fl);
        @(posedge clk);
        #1;
        chk_outputs("lat_after_edge", 32'd7, 1'b0, model_flags(32'd10, 32'd3));
        last_res = 32'd7;
        last_z   = 1'b0;
        last_fl  = model_flags(32'd10, 32'd3);

        // Hold: en=0 with changed inputs keeps every output
        @(negedge clk);
        en = 1'b0;
        A = 32'd0;
        B = 32'd0;
        aluControl = 4'h2;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("hold", last_res, last_z, last_fl);

        // Reset between edges: outputs clear immediately, pending capture dropped
        @(negedge clk);
        A = 32'd5;
        B = 32'd3;
        aluControl = 4'h0;
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("rst_async", 32'd0, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        chk_outputs("rst_held", 32'd0, 1'b0, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("rst_release_en0", 32'd0, 1'b0, 6'd0);

        // Reserved opcodes give zero with zero flag set
        step("res_d",    32'd5, 32'd3, 4'hD, 32'd0);
        step("nz_pre",   32'd5, 32'd3, 4'h3, 32'd7);
        step("res_e",    32'd5, 32'd3, 4'hE, 32'd0);
        step("nz_pre2",  32'hDEAD_BEEF, 32'd1, 4'h9, 32'd1);
        step("res_f",    32'hDEAD_BEEF, 32'd1, 4'hF, 32'd0);

        @(negedge clk);
        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
